// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// Start/done handshake; quotient/remainder registers change only on entry to DONE.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] rem_acc;
    logic [WIDTH-1:0] quo_acc;
    logic [WIDTH-1:0] dsr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    // One restoring step. The stored remainder is always below the divisor, so it
    // fits in WIDTH bits; only the shifted trial needs the extra bit, whose MSB is the borrow.
    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [WIDTH-1:0] r,
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] trial;
        shifted = {r, q[WIDTH-1]};
        trial   = shifted - {1'b0, d};
        if (trial[WIDTH])
            return {shifted[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
        else
            return {trial[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
    endfunction

    always_comb begin
        {rem_nxt, quo_nxt} = div_step(rem_acc, quo_acc, dsr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            rem_acc     <= '0;
            quo_acc     <= '0;
            dsr         <= '0;
            count       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dsr     <= divisor;
                        quo_acc <= dividend;
                        rem_acc <= '0;
                        count   <= '0;
                        busy    <= 1'b1;
                        if (divisor == '0) begin
                            // Skip the iteration entirely: report saturated quotient.
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_acc <= rem_nxt;
                    quo_acc <= quo_nxt;
                    count   <= count + CW'(1);
                    if (count == LAST) begin
                        state       <= DONE;
                        done        <= 1'b1;
                        quotient    <= quo_nxt;
                        remainder   <= rem_nxt;
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus a randomized sweep,
// compared every cycle against a latency/arithmetic model built from / and %.
module tb_seq_divider;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: an accepted op finishes WIDTH edges later with dividend/divisor results.
    logic             m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
    logic [WIDTH-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0, m_a = '0, m_d = '0;
    int               m_left = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
            m_q <= '0; m_r <= '0; m_left <= 0;
        end else if (m_done) begin
            m_done <= 1'b0; m_busy <= 1'b0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1; m_q <= p_q; m_r <= p_r; m_dbz <= 1'b0;
            end
        end else if (start) begin
            m_a <= dividend; m_d <= divisor; m_busy <= 1'b1;
            if (divisor == '0) begin
                m_done <= 1'b1; m_q <= '1; m_r <= dividend; m_dbz <= 1'b1;
            end else begin
                p_q <= dividend / divisor; p_r <= dividend % divisor; m_left <= WIDTH;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("div_by_zero", div_by_zero, m_dbz);
            check("quotient", quotient, m_q);
            check("remainder", remainder, m_r);
            if (done && !div_by_zero && m_d != '0) begin
                check("q*d+r==a", 32'(quotient) * 32'(m_d) + 32'(remainder), 32'(m_a));
                check("r<d", remainder < m_d, 1);
            end
        end
    end

    // Counts edges from the accept edge (inclusive) to the edge that raises done.
    task automatic wait_done(output int edges, output bit seen);
        edges = 0;
        seen  = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            start = 1'b0;
            if (i > 0) begin
                dividend = WIDTH'($urandom);
                divisor  = WIDTH'($urandom);
            end
            if (done) seen = 1'b1;
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d,
                          input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                          input logic edbz, input int elat, input string tag);
        int edges;
        bit seen;
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = d;
        wait_done(edges, seen);
        check({tag, " done seen"}, seen, 1);
        check({tag, " latency"}, edges, elat);
        check({tag, " q"}, quotient, eq);
        check({tag, " r"}, remainder, er);
        check({tag, " dbz"}, div_by_zero, edbz);
    endtask

    initial begin
        int edges;
        bit seen;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset q", quotient, 0);
        check("reset r", remainder, 0);
        check("reset dbz", div_by_zero, 0);
        rst_n = 1'b1;

        run_op(16'd390, 16'd3, 16'd130, 16'd0, 1'b0, 17, "390/3");
        run_op(16'hFFFF, 16'h0001, 16'hFFFF, 16'd0, 1'b0, 17, "FFFF/1");
        run_op(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 17, "FFFF/FFFF");
        run_op(16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 17, "5/9");
        run_op(16'd0, 16'd7, 16'd0, 16'd0, 1'b0, 17, "0/7");
        run_op(16'd7, 16'd0, 16'hFFFF, 16'd7, 1'b1, 1, "7/0");
        run_op(16'd10, 16'd4, 16'd2, 16'd2, 1'b0, 17, "10/4");

        // Start pulse during RUN must be ignored.
        @(negedge clk);
        start = 1'b1; dividend = 16'd1000; divisor = 16'd7;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        start = 1'b1; dividend = 16'd20; divisor = 16'd5;
        wait_done(edges, seen);
        check("ignore-start done seen", seen, 1);
        check("ignore-start q", quotient, 16'd142);
        check("ignore-start r", remainder, 16'd6);
        @(negedge clk);
        check("ignore-start idle", busy, 0);

        // Reset in the middle of RUN aborts without a done pulse.
        @(negedge clk);
        start = 1'b1; dividend = 16'd1000; divisor = 16'd7;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort q", quotient, 0);
        check("abort r", remainder, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run_op(16'd100, 16'd10, 16'd10, 16'd0, 1'b0, 17, "100/10");

        // Random sweep with held/pulsed start, occasional zero divisors and resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 299) != 0);
            start = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0: dividend = '0;
                1: dividend = WIDTH'($urandom_range(0, 31));
                default: dividend = WIDTH'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0: divisor = '0;
                1: divisor = 16'd1;
                2: divisor = WIDTH'($urandom_range(1, 15));
                3: divisor = 16'hFFFF;
                default: divisor = WIDTH'($urandom);
            endcase
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (25) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
